// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 parallel-bus source: VGA-style vsync/href framing with selectable RGB565 test
// images, two bytes per pixel, high byte first.
module ov7670_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 288,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int BOX_W    = 64,
  parameter int BOX_H    = 480,
  parameter int BOX_STEP = 16
) (
  input  logic        ov_pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        ov_vs,
  output logic        ov_hs,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [2:0]  dbg_state
);

  localparam int LT     = 2 * H_ACTIVE + H_BLANK;
  localparam int BAR_PX = H_ACTIVE / 8;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t      state_q, state_d;
  logic [15:0] h_q, h_d, l_q, l_d;
  logic [2:0]  bar_q, bar_d;
  logic [15:0] bar_cnt_q, bar_cnt_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] color_q, color_d;
  logic [15:0] box_x_q, box_x_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        ov_vs_q, ov_vs_d, ov_hs_q, ov_hs_d, frame_done_q, frame_done_d;
  logic [7:0]  cam_data_q, cam_data_d;

  logic [15:0] lines_n, px, py, pixel;
  logic [15:0] bar_color;
  logic        line_end;

  // Outputs are registered from the next position (state_d/h_d/l_d), so they line up with it.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    l_d         = l_q;
    bar_d       = bar_q;
    bar_cnt_d   = bar_cnt_q;
    pat_d       = pat_q;
    color_d     = color_q;
    box_x_d     = box_x_q;
    frame_cnt_d = frame_cnt_q;
    lines_n     = 16'd1;
    line_end    = (h_q == 16'(LT - 1));

    case (state_q)
      S_VSYNC:  lines_n = 16'(V_SYNC);
      S_VBACK:  lines_n = 16'(V_BACK);
      S_ACTIVE: lines_n = 16'(V_ACTIVE);
      S_VFRONT: lines_n = 16'(V_FRONT);
      default:  lines_n = 16'd1;
    endcase

    if (state_q == S_IDLE) begin
      if (en) begin
        state_d = S_VSYNC;
        h_d     = 16'd0;
        l_d     = 16'd0;
      end
    end else begin
      h_d = line_end ? 16'd0 : h_q + 16'd1;
      if (line_end) begin
        if (l_q == lines_n - 16'd1) begin
          l_d = 16'd0;
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            S_VFRONT: state_d = en ? S_VSYNC : S_IDLE;
            default:  state_d = S_IDLE;
          endcase
        end else begin
          l_d = l_q + 16'd1;
        end
      end
    end

    if (state_d == S_VSYNC && state_q != S_VSYNC) begin
      pat_d   = pattern_sel;
      color_d = solid_color;
    end

    // Bar tracking steps once per pixel (even byte) instead of dividing px.
    if (h_d == 16'd0) begin
      bar_d     = 3'd0;
      bar_cnt_d = 16'd0;
    end else if (!h_d[0]) begin
      if (bar_cnt_q == 16'(BAR_PX - 1)) begin
        bar_d     = bar_q + 3'd1;
        bar_cnt_d = 16'd0;
      end else begin
        bar_cnt_d = bar_cnt_q + 16'd1;
      end
    end

    frame_done_d = (state_d == S_VFRONT) && (h_d == 16'(LT - 1)) && (l_d == 16'(V_FRONT - 1));
    if (frame_done_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (box_x_q + 16'(BOX_STEP) + 16'(BOX_W) > 16'(H_ACTIVE)) box_x_d = 16'd0;
      else                                                      box_x_d = box_x_q + 16'(BOX_STEP);
    end

    px = {1'b0, h_d[15:1]};
    py = l_d;
    case (bar_d)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
    case (pat_d)
      2'd0:    pixel = bar_color;
      2'd1:    pixel = {py[4:0], px[5:0], px[4:0]};
      2'd2:    pixel = color_d;
      default: pixel = (px >= box_x_q && px < box_x_q + 16'(BOX_W) && py < 16'(BOX_H))
                       ? 16'hFFFF : 16'h0000;
    endcase

    ov_vs_d    = (state_d == S_VSYNC);
    ov_hs_d    = (state_d == S_ACTIVE) && (h_d < 16'(2 * H_ACTIVE));
    cam_data_d = ov_hs_d ? (h_d[0] ? pixel[7:0] : pixel[15:8]) : 8'd0;
  end

  always_ff @(posedge ov_pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      h_q          <= 16'd0;
      l_q          <= 16'd0;
      bar_q        <= 3'd0;
      bar_cnt_q    <= 16'd0;
      pat_q        <= 2'd0;
      color_q      <= 16'd0;
      box_x_q      <= 16'd0;
      frame_cnt_q  <= 16'd0;
      ov_vs_q      <= 1'b0;
      ov_hs_q      <= 1'b0;
      cam_data_q   <= 8'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      l_q          <= l_d;
      bar_q        <= bar_d;
      bar_cnt_q    <= bar_cnt_d;
      pat_q        <= pat_d;
      color_q      <= color_d;
      box_x_q      <= box_x_d;
      frame_cnt_q  <= frame_cnt_d;
      ov_vs_q      <= ov_vs_d;
      ov_hs_q      <= ov_hs_d;
      cam_data_q   <= cam_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ov_vs      = ov_vs_q;
  assign ov_hs      = ov_hs_q;
  assign cam_data   = cam_data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen with small timing parameters: every cycle of every frame is
// compared against a frame-position model built from line/column arithmetic.
module tb_ov7670_stream_gen;

  localparam int HA = 8, HB = 4, VS = 1, VB = 1, VA = 2, VF = 1;
  localparam int BW = 2, BH = 1, BS = 2;
  localparam int LT = 2 * HA + HB;
  localparam int FL = LT * (VS + VB + VA + VF);

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_color;
  logic        ov_vs, ov_hs, frame_done;
  logic [7:0]  cam_data;
  logic [15:0] frame_cnt;
  logic [2:0]  dbg_state;

  int tests, fails;
  int mdl_cnt, mdl_box;
  logic [15:0] bars [8];

  ov7670_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .BOX_W(BW), .BOX_H(BH), .BOX_STEP(BS)
  ) dut (
    .ov_pclk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .solid_color(solid_color),
    .ov_vs(ov_vs), .ov_hs(ov_hs), .cam_data(cam_data), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int pat, input logic [15:0] col, input int px, input int py);
    logic [15:0] g;
    case (pat)
      0: return bars[px / (HA / 8)];
      1: begin
        g = {py[4:0], px[5:0], px[4:0]};
        return g;
      end
      2: return col;
      default: return (px >= mdl_box && px < mdl_box + BW && py < BH) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Expected {vs, hs, data, done, frame_cnt} at cycle i of a frame (cycle 0 = first vsync cycle).
  function automatic logic [26:0] exp_at(input int i, input int pat, input logic [15:0] col);
    int line, h, cnt;
    bit vs, hs, act, done;
    logic [15:0] p;
    logic [7:0] d;
    line = i / LT;
    h    = i % LT;
    vs   = line < VS;
    act  = (line >= VS + VB) && (line < VS + VB + VA);
    hs   = act && (h < 2 * HA);
    d    = 8'h00;
    if (hs) begin
      p = pix(pat, col, h / 2, line - VS - VB);
      d = (h % 2 == 1) ? p[7:0] : p[15:8];
    end
    done = (i == FL - 1);
    cnt  = done ? mdl_cnt + 1 : mdl_cnt;
    return {vs, hs, d, done, 16'(cnt)};
  endfunction

  function automatic logic [26:0] obs_now();
    return {ov_vs, ov_hs, cam_data, frame_done, frame_cnt};
  endfunction

  // driver: one frame; inputs for this frame were set by the caller before the entry edge
  task automatic run_frame(input int pat, input logic [15:0] col, input bit drop_en,
                           input int abort_at);
    int k;
    k = $urandom_range(LT * (VS + VB), LT * (VS + VB + VA) - 2);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        #1 rst = 1'b0;
        #1 check("rst_async", {ov_vs, ov_hs, cam_data, frame_cnt}, 32'd0);
        return;
      end
      check($sformatf("frame_p%0d_c%0d", pat, i), 32'(obs_now()), 32'(exp_at(i, pat, col)));
      if (i == k) begin
        pattern_sel = 2'($urandom);
        solid_color = 16'($urandom);
      end
      if (drop_en && i == LT * VS + 1) en = 1'b0;
    end
    mdl_cnt = (mdl_cnt + 1) & 16'hFFFF;
    mdl_box = (mdl_box + BS + BW > HA) ? 0 : mdl_box + BS;
  endtask

  task automatic start_frame(input int pat, input logic [15:0] col, input bit drop_en,
                             input int abort_at);
    pattern_sel = 2'(pat);
    solid_color = col;
    en          = 1'b1;
    run_frame(pat, col, drop_en, abort_at);
  endtask

  initial begin
    int p;
    logic [15:0] c;
    tests = 0; fails = 0; mdl_cnt = 0; mdl_box = 0;
    bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
    bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
    rst = 1'b0; en = 1'b0; pattern_sel = 2'd0; solid_color = 16'd0;

    // reset state
    #1 check("reset_outs", 32'(obs_now()), 32'd0);
    repeat (2) @(negedge clk);
    check("reset_hold", 32'(obs_now()), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_en0", 32'(obs_now()), 32'd0);
    end

    // directed frames: solid A55A, colour bars, moving box across the wrap
    start_frame(2, 16'hA55A, 1'b0, -1);
    start_frame(0, 16'h1234, 1'b0, -1);
    repeat (5) start_frame(3, 16'($urandom), 1'b0, -1);

    // randomized frames
    repeat (8) begin
      p = $urandom_range(0, 3);
      c = 16'($urandom);
      start_frame(p, c, 1'b0, -1);
    end

    // en dropped during VBACK: frame completes, then IDLE
    start_frame(1, 16'($urandom), 1'b1, -1);
    repeat (5) begin
      @(negedge clk);
      check("idle_after_drop", {ov_vs, ov_hs, cam_data, frame_done}, 32'd0);
      check("cnt_hold", 32'(frame_cnt), 32'(mdl_cnt));
    end
    check("idle_state", 32'(dbg_state), 32'd0);
    start_frame(0, 16'h0, 1'b0, -1);

    // reset mid-line with href high
    start_frame(2, 16'($urandom), 1'b0, LT * (VS + VB) + 5);
    mdl_cnt = 0;
    mdl_box = 0;
    repeat (2) begin
      @(negedge clk);
      check("in_reset", 32'(obs_now()), 32'd0);
    end
    rst = 1'b1;
    start_frame(3, 16'h0, 1'b0, -1);
    start_frame(2, 16'h5AA5, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
